// File: rtl/window_controller.sv
`timescale 1ns/1ps
// window_controller: valid/ready front-end for the sliding-window buffer. Forwards each
// accepted sample to the windower and launches the encoder after every full/stepped window.
module window_controller #(
    parameter int NUM_CHS     = 4,
    parameter int SAMPLE_SIZE = 16,
    parameter int WINDOW_SIZE = 256,
    parameter int WINDOW_STEP = 128,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic                           run,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_CHS*SAMPLE_SIZE-1:0] in_samples,
    output logic                           win_en,
    output logic [NUM_CHS*SAMPLE_SIZE-1:0] win_samples,
    output logic                           enc_start,
    input  logic                           enc_done,
    output logic                           active,
    output logic                           overrun,
    output logic [COUNT_WIDTH-1:0]         win_count
);

    localparam int DW = NUM_CHS * SAMPLE_SIZE;
    localparam int CW = $clog2(WINDOW_SIZE + 1);
    localparam logic [CW-1:0] FILL_LAST = CW'(WINDOW_SIZE - 1);
    localparam logic [CW-1:0] STEP_LAST = CW'(WINDOW_STEP - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        FLUSH = 3'd2,
        START = 3'd3,
        WAIT  = 3'd4,
        STEP  = 3'd5
    } state_t;

    state_t                 state_r;
    state_t                 next_state_s;
    logic [CW-1:0]          samp_cnt_r;
    logic                   in_ready_s;
    logic                   accept_s;
    logic                   win_en_r;
    logic [DW-1:0]          win_samples_r;
    logic                   enc_start_r;
    logic                   active_r;
    logic                   overrun_r;
    logic [COUNT_WIDTH-1:0] win_count_r;

    // The window memory is only writable while collecting samples.
    assign in_ready_s = run && ((state_r == FILL) || (state_r == STEP));
    assign accept_s   = in_valid && in_ready_s;

    // Next-state decode; run-low aborts collection at once but never an in-flight launch.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (run) next_state_s = FILL;
                else     next_state_s = IDLE;
            end
            FILL: begin
                if (!run)                                       next_state_s = IDLE;
                else if (accept_s && (samp_cnt_r == FILL_LAST)) next_state_s = FLUSH;
                else                                            next_state_s = FILL;
            end
            FLUSH:   next_state_s = START;
            START:   next_state_s = WAIT;
            WAIT: begin
                if (enc_done && run)  next_state_s = STEP;
                else if (enc_done)    next_state_s = IDLE;
                else                  next_state_s = WAIT;
            end
            STEP: begin
                if (!run)                                       next_state_s = IDLE;
                else if (accept_s && (samp_cnt_r == STEP_LAST)) next_state_s = FLUSH;
                else                                            next_state_s = STEP;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_r <= IDLE;
        else       state_r <= next_state_s;
    end

    // Sample counter; zero whenever not collecting, so every FILL/STEP entry starts clean.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)                                     samp_cnt_r <= {CW{1'b0}};
        else if ((state_r != FILL) && (state_r != STEP)) samp_cnt_r <= {CW{1'b0}};
        else if (accept_s)                             samp_cnt_r <= samp_cnt_r + CW'(1);
    end

    // Windower write path: registered sample plus one-cycle enable.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            win_en_r      <= 1'b0;
            win_samples_r <= {DW{1'b0}};
        end else begin
            win_en_r <= accept_s;
            if (accept_s) win_samples_r <= in_samples;
        end
    end

    // Launch pulse, activity flag, sticky overrun and launch counter.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            enc_start_r <= 1'b0;
            active_r    <= 1'b0;
            overrun_r   <= 1'b0;
            win_count_r <= {COUNT_WIDTH{1'b0}};
        end else begin
            enc_start_r <= (next_state_s == START);
            active_r    <= (next_state_s != IDLE);
            overrun_r   <= overrun_r | (run && in_valid && !in_ready_s);
            if (state_r == START) win_count_r <= win_count_r + COUNT_WIDTH'(1);
        end
    end

    assign in_ready    = in_ready_s;
    assign win_en      = win_en_r;
    assign win_samples = win_samples_r;
    assign enc_start   = enc_start_r;
    assign active      = active_r;
    assign overrun     = overrun_r;
    assign win_count   = win_count_r;

endmodule

// File: tb/tb_window_controller.sv
`timescale 1ns/1ps
// Scoreboard bench for window_controller: the driver queues expected windower writes and
// launches, an independent monitor pops and compares them when the DUT presents them.
module tb_window_controller;

    localparam int NUM_CHS     = 2;
    localparam int SAMPLE_SIZE = 2;
    localparam int WINDOW_SIZE = 4;
    localparam int WINDOW_STEP = 2;
    localparam int COUNT_WIDTH = 16;
    localparam int DW          = NUM_CHS * SAMPLE_SIZE;

    logic                   clk = 1'b0;
    logic                   nrst;
    logic                   run;
    logic                   in_valid;
    logic                   in_ready;
    logic [DW-1:0]          in_samples;
    logic                   win_en;
    logic [DW-1:0]          win_samples;
    logic                   enc_start;
    logic                   enc_done = 1'b0;
    logic                   active;
    logic                   overrun;
    logic [COUNT_WIDTH-1:0] win_count;

    window_controller #(
        .NUM_CHS(NUM_CHS), .SAMPLE_SIZE(SAMPLE_SIZE), .WINDOW_SIZE(WINDOW_SIZE),
        .WINDOW_STEP(WINDOW_STEP), .COUNT_WIDTH(COUNT_WIDTH)
    ) dut (
        .clk(clk), .nrst(nrst), .run(run), .in_valid(in_valid), .in_ready(in_ready),
        .in_samples(in_samples), .win_en(win_en), .win_samples(win_samples),
        .enc_start(enc_start), .enc_done(enc_done), .active(active), .overrun(overrun),
        .win_count(win_count)
    );

    typedef struct { int cyc; logic [DW-1:0] data; } win_exp_t;
    typedef struct { int cyc; int wc; } start_exp_t;

    win_exp_t   sb_win[$];
    start_exp_t sb_start[$];
    int         start_cycles[$];
    int         cyc        = 0;
    int         n_tests    = 0;
    int         n_fail     = 0;
    int         wc_exp     = 0;
    bit         wc_pending = 1'b0;
    int         wc_want    = 0;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares windower writes and launches against the scoreboard queues.
    initial forever begin
        win_exp_t   we;
        start_exp_t se;
        @(negedge clk);
        if (nrst) begin
            if (wc_pending) begin
                check_eq("win_count_after_start", win_count, wc_want);
                wc_pending = 1'b0;
            end
            if (win_en) begin
                if (sb_win.size() == 0) check_eq("win_en_unexpected", win_en, 0);
                else begin
                    we = sb_win.pop_front();
                    check_eq("win_en_cycle", cyc, we.cyc);
                    check_eq("win_samples", win_samples, we.data);
                end
            end else if (sb_win.size() != 0 && sb_win[0].cyc <= cyc) begin
                we = sb_win.pop_front();
                check_eq("win_en_missing", win_en, 1);
            end
            if (enc_start) begin
                start_cycles.push_back(cyc);
                if (sb_start.size() == 0) check_eq("enc_start_unexpected", enc_start, 0);
                else begin
                    se = sb_start.pop_front();
                    check_eq("enc_start_cycle", cyc, se.cyc);
                    wc_pending = 1'b1;
                    wc_want    = se.wc;
                end
            end else if (sb_start.size() != 0 && sb_start[0].cyc <= cyc) begin
                se = sb_start.pop_front();
                check_eq("enc_start_missing", enc_start, 1);
            end
        end
    end

    // Encoder model: enc_done five cycles after each launch.
    initial forever begin
        @(negedge clk);
        if (nrst && enc_start) begin
            repeat (5) @(posedge clk);
            #1 enc_done = 1'b1;
            @(posedge clk);
            #1 enc_done = 1'b0;
        end
    end

    // Offer one sample until accepted; queue its write and, for a window's last sample, the launch.
    task automatic send(input logic [DW-1:0] d, input bit last);
        int         w = 0;
        win_exp_t   we;
        start_exp_t se;
        in_valid   = 1'b1;
        in_samples = d;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check_eq("accept", in_ready, 1);
        if (in_ready) begin
            we.cyc = cyc + 1;
            we.data = d;
            sb_win.push_back(we);
            if (last) begin
                wc_exp++;
                se.cyc = cyc + 2;
                se.wc  = wc_exp;
                sb_start.push_back(se);
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_sig(input bit want_ready, input string name, input int maxc);
        bit seen = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge clk);
            seen = want_ready ? in_ready : enc_start;
        end
        check_eq(name, seen, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_in_ready"},    in_ready, 0);
        check_eq({tag, "_win_en"},      win_en, 0);
        check_eq({tag, "_win_samples"}, win_samples, 0);
        check_eq({tag, "_enc_start"},   enc_start, 0);
        check_eq({tag, "_active"},      active, 0);
        check_eq({tag, "_overrun"},     overrun, 0);
        check_eq({tag, "_win_count"},   win_count, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nrst = 1'b0; run = 1'b0; in_valid = 1'b0; in_samples = '0;
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("idle_active", active, 0);
        check_eq("idle_in_ready", in_ready, 0);

        // First fill
        @(posedge clk); #1 run = 1'b1;
        @(posedge clk); #1;
        send(4'b0101, 1'b0);
        send(4'b1010, 1'b0);
        send(4'b1111, 1'b0);
        send(4'b0000, 1'b1);
        check_eq("overrun_clean_fill", overrun, 0);

        // Step: source holds valid through WAIT
        fork
            begin
                send(4'b0110, 1'b0);
                send(4'b1001, 1'b1);
            end
            begin
                repeat (7) begin
                    @(negedge clk);
                    check_eq("in_ready_wait", in_ready, 0);
                end
            end
        join
        check_eq("overrun_set", overrun, 1);
        wait_sig(1'b0, "second_start_seen", 20);
        if (start_cycles.size() >= 2)
            check_eq("launch_period", start_cycles[1] - start_cycles[0], 9);
        wait_sig(1'b1, "step_reached", 20);
        @(posedge clk); #1 run = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("step_abort_active", active, 0);

        // Abort mid-fill, then refill the whole window
        @(posedge clk); #1 run = 1'b1;
        @(posedge clk); #1;
        send(4'b0011, 1'b0);
        send(4'b1100, 1'b0);
        run = 1'b0;
        @(negedge clk);
        check_eq("abort_active_same_cycle", active, 1);
        @(negedge clk);
        check_eq("abort_active", active, 0);
        check_eq("abort_win_en", win_en, 0);
        @(posedge clk); #1 run = 1'b1;
        @(posedge clk); #1;
        send(4'b0001, 1'b0);
        send(4'b0010, 1'b0);
        send(4'b0100, 1'b0);
        send(4'b1000, 1'b1);

        // Run low during WAIT
        wait_sig(1'b0, "third_start_seen", 10);
        @(posedge clk); #1 run = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_eq("wait_hold_active", active, 1);
        end
        @(negedge clk);
        check_eq("wait_exit_active", active, 0);
        check_eq("wait_exit_in_ready", in_ready, 0);

        // Async reset mid-STEP with win_en high
        @(posedge clk); #1 run = 1'b1;
        @(posedge clk); #1;
        send(4'b1011, 1'b0);
        send(4'b1101, 1'b0);
        send(4'b0111, 1'b0);
        send(4'b1110, 1'b1);
        wait_sig(1'b1, "step_before_reset", 20);
        @(posedge clk); #1;
        send(4'b0101, 1'b0);
        check_eq("win_en_before_reset", win_en, 1);
        nrst = 1'b0;
        #1 check_all_zero("async_reset");
        sb_win.delete();
        sb_start.delete();
        wc_pending = 1'b0;
        wc_exp     = 0;
        @(posedge clk); #1 nrst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send(4'b0001, 1'b0);
        send(4'b0011, 1'b0);
        send(4'b0111, 1'b0);
        send(4'b1111, 1'b1);
        repeat (6) @(negedge clk);
        run = 1'b0;
        repeat (10) @(negedge clk);

        check_eq("sb_win_empty", sb_win.size(), 0);
        check_eq("sb_start_empty", sb_start.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
